// File: rtl/result_unloader.sv
// result_unloader
//   Captures a wide multiplier product on the rising edge of done and streams
//   it out as WORD_W-bit words, least-significant word first, over a
//   valid/ready handshake. Unused high bits of the last word are zero.
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-low reset
//   W          in   product, sampled on the capture edge
//   done       in   multiplier completion level
//   out_ready  in   downstream accepts the current word
//   out_data   out  current word (register bits of the holding buffer)
//   out_valid  out  out_data is valid
//   out_last   out  current word is word NWORDS-1
//   busy       out  a product is held or is being streamed
//   overrun    out  sticky: a product arrived mid-stream and was dropped
//
// States
//   S_IDLE   | nothing held; waits for a rising edge of done
//   S_STREAM | product held; presents buffer's low word until accepted
module result_unloader #(
  parameter int WORD_W = 64,
  parameter int RES_W  = 35338,
  parameter int NWORDS = (RES_W + WORD_W - 1) / WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RES_W-1:0]  W,
  input  logic              done,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int BUF_W = NWORDS * WORD_W;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               done_q;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               overrun_q, overrun_d;

  logic capture;
  logic streaming;
  logic xfer;
  logic at_last;
  logic final_xfer;
  logic load;

  assign capture    = done & ~done_q;
  assign streaming  = (state_q == S_STREAM);
  assign xfer       = streaming & out_ready;
  assign at_last    = (idx_q == LAST_IDX);
  assign final_xfer = xfer & at_last;
  // A capture is accepted when idle, or when it lands exactly on the final
  // transfer so back-to-back products stream without a bubble.
  assign load       = capture & (~streaming | final_xfer);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (capture) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (final_xfer && !capture) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid = streaming;
    busy      = streaming;
    out_last  = streaming & at_last;
    // The buffer is all zeros whenever the FSM is idle: reset clears it and
    // NWORDS right shifts of an NWORDS-word buffer drain it completely.
    out_data  = buf_q[WORD_W-1:0];
    overrun   = overrun_q;
  end

  // Datapath next-state
  always_comb begin
    buf_d     = buf_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    if (load) begin
      buf_d = BUF_W'(W);
      idx_d = '0;
    end else if (xfer) begin
      buf_d = buf_q >> WORD_W;
      idx_d = at_last ? '0 : idx_q + IDX_W'(1);
    end
    if (capture && streaming && !final_xfer) begin
      overrun_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q    <= 1'b0;
      buf_q     <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      done_q    <= done;
      buf_q     <= buf_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
module tb_result_unloader;
  localparam int WORD_W = 64;
  localparam int RES_W  = 35338;
  localparam int NWORDS = 553;
  localparam int BUF_W  = NWORDS * WORD_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [RES_W-1:0]  W = '0;
  logic              done = 1'b0;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_last;
  logic              busy;
  logic              overrun;

  int checks = 0;
  int errors = 0;

  result_unloader #(.WORD_W(WORD_W), .RES_W(RES_W), .NWORDS(NWORDS)) dut (
    .clk(clk), .reset(reset), .W(W), .done(done), .out_ready(out_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference view of a product: zero-extended to whole words, word k is
  // simply bits [k*64 +: 64].
  function automatic logic [BUF_W-1:0] ext(input logic [RES_W-1:0] w);
    return BUF_W'(w);
  endfunction

  function automatic logic [RES_W-1:0] rand_w();
    logic [BUF_W-1:0] t;
    for (int i = 0; i < BUF_W / 32; i++) t[i*32 +: 32] = $urandom();
    return t[RES_W-1:0];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_last"},  64'(out_last),  64'd0);
    check({tag, "_data"},  out_data,       64'd0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the
  // capture edge.
  task automatic start_product(input logic [RES_W-1:0] w, input bit hold);
    check("pre_capture_valid", 64'(out_valid), 64'd0);
    W = w;
    done = 1'b1;
    @(negedge clk);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("latency_busy",  64'(busy),      64'd1);
    if (!hold) done = 1'b0;
  endtask

  // Consumes one product with random stalls and checks every word. Optional
  // one-cycle done pulse carrying evt_w when word evt_idx is presented, and
  // optional early return once word abort_idx is reached.
  task automatic stream_check(input logic [BUF_W-1:0] wx, input int stall_pct,
                              input int evt_idx, input logic [RES_W-1:0] evt_w,
                              input int abort_idx);
    int k = 0;
    int cyc = 0;
    bit injected = 1'b0;
    bit stalled = 1'b0;
    bit rdy;
    logic [63:0] pd = '0;
    logic pl = 1'b0;
    while (k < NWORDS && cyc < 20000) begin
      if (abort_idx >= 0 && k == abort_idx) return;
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_busy",  64'(busy),      64'd1);
      if (stalled) begin
        check("stall_data", out_data,      pd);
        check("stall_last", 64'(out_last), 64'(pl));
      end
      if (evt_idx >= 0 && k == evt_idx && !injected) begin
        W = evt_w;
        done = 1'b1;
        injected = 1'b1;
      end else if (injected) begin
        done = 1'b0;
      end
      if (evt_idx >= 0 && k == evt_idx) rdy = 1'b1;
      else rdy = ($urandom_range(0, 99) >= stall_pct);
      out_ready = rdy;
      if (rdy) begin
        check("word", out_data, wx[k*WORD_W +: WORD_W]);
        check("word_last", 64'(out_last), 64'(k == NWORDS - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        pd = out_data;
        pl = out_last;
      end
      @(negedge clk);
      cyc++;
    end
    check("stream_transfers", 64'(k), 64'(NWORDS));
  endtask

  initial begin
    logic [RES_W-1:0] w1, w2, ones;

    #12;
    check("rst_data",    out_data,       64'd0);
    check("rst_valid",   64'(out_valid), 64'd0);
    check("rst_last",    64'(out_last),  64'd0);
    check("rst_busy",    64'(busy),      64'd0);
    check("rst_overrun", 64'(overrun),   64'd0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle("idle0");

    // W = 1
    start_product(RES_W'(1), 1'b0);
    stream_check(ext(RES_W'(1)), 0, -1, '0, -1);
    check_idle("one_end");
    check("one_overrun", 64'(overrun), 64'd0);

    // W = all ones; last word carries the 10 top bits
    ones = '1;
    start_product(ones, 1'b0);
    stream_check(ext(ones), 0, -1, '0, -1);
    check_idle("ones_end");

    // Random products with ~30% stalls
    for (int n = 0; n < 2; n++) begin
      w1 = rand_w();
      start_product(w1, 1'b0);
      stream_check(ext(w1), 30, -1, '0, -1);
      check_idle("rand_end");
    end

    // New capture coinciding with the final transfer: no bubble, no overrun
    w1 = rand_w();
    w2 = rand_w();
    start_product(w1, 1'b0);
    stream_check(ext(w1), 30, NWORDS - 1, w2, -1);
    done = 1'b0;
    check("coincide_overrun", 64'(overrun), 64'd0);
    stream_check(ext(w2), 30, -1, '0, -1);
    check_idle("coincide_end");
    check("coincide_overrun_end", 64'(overrun), 64'd0);

    // Capture at idx 100 is dropped; held product intact; overrun sticky
    w1 = rand_w();
    w2 = rand_w();
    start_product(w1, 1'b0);
    stream_check(ext(w1), 30, 100, w2, -1);
    done = 1'b0;
    check("overrun_set", 64'(overrun), 64'd1);
    check_idle("overrun_end");
    repeat (5) @(negedge clk);
    check("overrun_sticky", 64'(overrun), 64'd1);

    // Reset mid-stream at idx 300, release with done high
    w1 = rand_w();
    w2 = rand_w();
    start_product(w1, 1'b0);
    stream_check(ext(w1), 30, -1, '0, 300);
    #2 reset = 1'b0;
    #1;
    check("async_rst_data",    out_data,       64'd0);
    check("async_rst_valid",   64'(out_valid), 64'd0);
    check("async_rst_last",    64'(out_last),  64'd0);
    check("async_rst_busy",    64'(busy),      64'd0);
    check("async_rst_overrun", 64'(overrun),   64'd0);
    @(negedge clk);
    check("in_rst_valid", 64'(out_valid), 64'd0);
    W = w2;
    done = 1'b1;
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_release_capture", 64'(out_valid), 64'd1);
    done = 1'b0;
    stream_check(ext(w2), 0, -1, '0, -1);
    check_idle("rst_restart_end");

    // done held high for 2000 cycles: exactly one product
    w1 = rand_w();
    start_product(w1, 1'b1);
    stream_check(ext(w1), 0, -1, '0, -1);
    for (int c = 0; c < 2000 - NWORDS - 1; c++) begin
      check("hold_no_recapture", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    done = 1'b0;
    @(negedge clk);
    check_idle("hold_end");
    check("hold_overrun", 64'(overrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_unloader.md
RESULT_UNLOADER -- requirements
Module: result_unloader

Interface
REQ-001 Parameter: WORD_W, 64, output word width in bits.
REQ-002 Parameter: RES_W, 35338, product width in bits, equal to the multiplier W width.
REQ-003 Parameter: NWORDS, ceil(RES_W/WORD_W) = 553, words per product.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 W  input  RES_W  product from the multiplier; valid while done is high.
REQ-007 done  input  1  multiplier completion level.
REQ-008 out_ready  input  1  downstream accepts a word.
REQ-009 out_data  output  WORD_W  current word, registered.
REQ-010 out_valid  output  1  out_data is valid.
REQ-011 out_last  output  1  current word is word NWORDS-1.
REQ-012 busy  output  1  a product is held or is being streamed.
REQ-013 overrun  output  1  sticky flag: a product was dropped.

Function
REQ-014 The block SHALL register done into done_q; the capture condition is done=1 and done_q=0.
REQ-015 The block SHALL have two states, IDLE and STREAM.
REQ-016 IDLE: out_valid=0, busy=0; on the capture condition the block SHALL load {padding, W} into an internal buffer, clear word index idx to 0, and enter STREAM.
REQ-017 STREAM: out_valid=1, busy=1, out_data = buffer[WORD_W-1:0], out_last = (idx==NWORDS-1).
REQ-018 A transfer SHALL occur only when out_valid=1 and out_ready=1 in the same cycle.
REQ-019 On each transfer the buffer SHALL shift right by WORD_W bits and idx SHALL increment.
REQ-020 With no transfer, out_data, out_last and idx SHALL hold.
REQ-021 Words SHALL be emitted least-significant first: word k = W[k*WORD_W +: WORD_W].
REQ-022 The last word SHALL be {54'b0, W[35337:35328]}; padding bits SHALL be 0.
REQ-023 Latency: out_valid SHALL rise in the cycle after the capture edge.
REQ-024 A product SHALL need exactly NWORDS transfers; at the transfer of idx=NWORDS-1 the block SHALL return to IDLE.
REQ-025 If a capture condition coincides with the final transfer, the block SHALL capture the new W and stay in STREAM with idx=0, with no bubble cycle.
REQ-026 A capture condition in STREAM other than in REQ-025 SHALL be ignored and SHALL set overrun=1; the held product SHALL be unaffected.
REQ-027 done staying high for many cycles SHALL capture only once; a new capture needs done to go low, then high again.
REQ-028 out_data SHALL be 0 in IDLE.

Reset
REQ-029 On reset=0, asynchronously: state=IDLE, idx=0, buffer=0, done_q=0, out_data=0, out_valid=0, out_last=0, busy=0, overrun=0.
REQ-030 Reset asserted mid-stream SHALL abandon the product; no further words SHALL be emitted.
REQ-031 If done is high at the first edge after reset release, that edge SHALL count as a capture condition (done_q=0).

Verification
REQ-032 W=1, done pulse, out_ready=1 -> out_valid at cycle+1; word0=1; words 1..552=0; out_last only on word 552; exactly 553 transfers, then IDLE.
REQ-033 W=all ones, out_ready=1 -> words 0..551=64'hFFFF_FFFF_FFFF_FFFF; word 552=64'h0000_0000_0000_03FF.
REQ-034 Random W, out_ready toggled randomly with about 30% stalls -> reassembled words match W bit-exactly; out_data and out_last stable while stalled.
REQ-035 Second done edge at idx=100 -> overrun=1; the first product streams intact. Second done edge in the cycle of word 552's transfer -> next cycle shows word0 of the new W, overrun stays 0.
REQ-036 reset=0 at idx=300 -> all outputs 0 asynchronously. Release with done=1 -> capture on the first edge, streaming restarts from word0.
REQ-037 done held high for 2000 cycles -> exactly one product (553 words) streamed.
